// File: rtl/bt_pkg.sv
// Shared widths, reset values and state encoding for the branch target unit.
package bt_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned PTR_W = 5;
  localparam int unsigned TBL_N = 1 << PTR_W;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam pc_t START_PC    = 10'h000;
  localparam pc_t TBL_DEFAULT = 10'h001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_target_unit_if.sv
// Decode/host-facing signal bundle of the branch target unit.
interface branch_target_unit_if;
  import bt_pkg::*;

  logic Start;
  logic TblWrEn;
  ptr_t TblWrAddr;
  pc_t  TblWrData;
  logic BranchEn;
  logic BranchTaken;
  ptr_t BranchPtr;
  logic RelMode;
  logic HaltReq;
  pc_t  PC;
  logic Running;
  logic Done;

  modport master (
    output Start, TblWrEn, TblWrAddr, TblWrData,
    output BranchEn, BranchTaken, BranchPtr, RelMode, HaltReq,
    input  PC, Running, Done
  );

  modport slave (
    input  Start, TblWrEn, TblWrAddr, TblWrData,
    input  BranchEn, BranchTaken, BranchPtr, RelMode, HaltReq,
    output PC, Running, Done
  );
endinterface

// File: rtl/target_table.sv
// Run-time loadable branch-target register file: one registered write port,
// one combinational read port returning the value stored before the edge.
module target_table
  import bt_pkg::*;
(
  input  logic Clk,
  input  logic Reset_n,
  input  logic wr_en,
  input  ptr_t wr_addr,
  input  pc_t  wr_data,
  input  ptr_t rd_addr,
  output pc_t  rd_data_c
);

  pc_t entries [TBL_N];

  // Full reset of every entry; a write coincident with reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < TBL_N; i++) begin
        entries[i] <= TBL_DEFAULT;
      end
    end else if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write is not forwarded.
  assign rd_data_c = entries[rd_addr];

endmodule

// File: rtl/branch_target_unit.sv
// PC sequencer: IDLE/RUN/HALT control with table-driven absolute or relative
// branches, one-cycle latency from decode inputs to PC.
module branch_target_unit
  import bt_pkg::*;
(
  input logic                       Clk,
  input logic                       Reset_n,
  branch_target_unit_if.slave       bus
);

  state_t state;
  pc_t    pc;
  logic   running;
  logic   done;
  pc_t    target_c;
  logic   taken_c;

  target_table u_table (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en     (bus.TblWrEn),
    .wr_addr   (bus.TblWrAddr),
    .wr_data   (bus.TblWrData),
    .rd_addr   (bus.BranchPtr),
    .rd_data_c (target_c)
  );

  assign taken_c = bus.BranchEn & bus.BranchTaken;

  // State, PC and status flags advance together so outputs stay registered.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pc      <= START_PC;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state   <= RUN;
            pc      <= START_PC;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (bus.HaltReq) begin
            state   <= HALT;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (taken_c && !bus.RelMode) begin
            pc <= target_c;
          end else if (taken_c) begin
            pc <= pc + target_c;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        HALT: begin
          if (bus.Start) begin
            state   <= RUN;
            pc      <= START_PC;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pc      <= START_PC;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC      = pc;
  assign bus.Running = running;
  assign bus.Done    = done;

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit with a behavioural reference model.
module tb_branch_target_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_target_unit_if bus ();

  branch_target_unit dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=idle, 1=running, 2=halted; PC modulo 1024.
  int mmode;
  int mpc;
  int mtbl [32];
  bit mvalid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mvalid <= 1'b1;
      mmode  <= 0;
      mpc    <= 0;
      for (int i = 0; i < 32; i++) mtbl[i] <= 1;
    end else begin
      if (bus.TblWrEn) mtbl[int'(bus.TblWrAddr)] <= int'(bus.TblWrData);
      case (mmode)
        0: if (bus.Start) begin mmode <= 1; mpc <= 0; end
        1: begin
          if (bus.HaltReq) mmode <= 2;
          else if (bus.BranchEn && bus.BranchTaken) begin
            if (bus.RelMode) mpc <= (mpc + mtbl[int'(bus.BranchPtr)]) % 1024;
            else             mpc <= mtbl[int'(bus.BranchPtr)];
          end else mpc <= (mpc + 1) % 1024;
        end
        default: if (bus.Start) begin mmode <= 1; mpc <= 0; end
      endcase
    end
  end

  // Every cycle once the model is anchored by reset, outputs must match it.
  always @(negedge clk) begin
    if (mvalid) begin
      check("model_pc", int'(bus.PC), mpc);
      check("model_running", int'(bus.Running), (mmode == 1) ? 1 : 0);
      check("model_done", int'(bus.Done), (mmode == 2) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.Start = 0; bus.TblWrEn = 0; bus.TblWrAddr = '0; bus.TblWrData = '0;
    bus.BranchEn = 0; bus.BranchTaken = 0; bus.BranchPtr = '0;
    bus.RelMode = 0; bus.HaltReq = 0;
  endtask

  task automatic branch(input logic [4:0] ptr, input logic rel);
    bus.BranchEn = 1; bus.BranchTaken = 1; bus.BranchPtr = ptr; bus.RelMode = rel;
    step();
    bus.BranchEn = 0; bus.BranchTaken = 0; bus.RelMode = 0;
  endtask

  task automatic tbl_write(input logic [4:0] a, input logic [9:0] d);
    bus.TblWrEn = 1; bus.TblWrAddr = a; bus.TblWrData = d;
    step();
    bus.TblWrEn = 0;
  endtask

  task automatic lit(input string name, input logic [9:0] pc, input logic r, input logic d);
    check({name, "_pc"}, int'(bus.PC), int'(pc));
    check({name, "_run"}, int'(bus.Running), int'(r));
    check({name, "_done"}, int'(bus.Done), int'(d));
  endtask

  initial begin
    idle_inputs();
    step(); step();
    lit("reset", 10'h000, 0, 0);
    rst_n = 1;
    step();
    lit("idle_hold", 10'h000, 0, 0);

    bus.Start = 1; step(); bus.Start = 0;
    lit("start", 10'h000, 1, 0);
    step(); lit("seq1", 10'h001, 1, 0);
    step(); lit("seq2", 10'h002, 1, 0);
    step(); lit("seq3", 10'h003, 1, 0);
    step(); lit("seq4", 10'h004, 1, 0);

    for (int i = 0; i < 32; i++) begin
      branch(5'(i), 0);
      check("default_entry", int'(bus.PC), 1);
    end

    tbl_write(5'd0, 10'h01C);
    tbl_write(5'd5, 10'h077);
    tbl_write(5'd1, 10'h031);
    tbl_write(5'd2, 10'h3F0);
    tbl_write(5'd3, 10'h020);
    tbl_write(5'd4, 10'h3FC);
    tbl_write(5'd6, 10'h064);
    tbl_write(5'd7, 10'h052);

    bus.HaltReq = 1; step(); bus.HaltReq = 0;
    check("halt_done", int'(bus.Done), 1);
    bus.Start = 1; step(); bus.Start = 0;
    lit("restart", 10'h000, 1, 0);
    step(); step(); step();
    lit("at3", 10'h003, 1, 0);

    branch(5'd0, 0); lit("abs0", 10'h01C, 1, 0);
    branch(5'd5, 0); lit("abs5", 10'h077, 1, 0);
    branch(5'd3, 0); lit("abs3", 10'h020, 1, 0);
    branch(5'd2, 1); lit("rel_neg16", 10'h010, 1, 0);
    branch(5'd4, 0); lit("abs4", 10'h3FC, 1, 0);
    step(); step(); step();
    lit("at3ff", 10'h3FF, 1, 0);
    step(); lit("wrap", 10'h000, 1, 0);

    bus.TblWrEn = 1; bus.TblWrAddr = 5'd1; bus.TblWrData = 10'h040;
    branch(5'd1, 0); bus.TblWrEn = 0;
    lit("same_edge_old", 10'h031, 1, 0);
    branch(5'd1, 0); lit("same_edge_new", 10'h040, 1, 0);

    bus.BranchTaken = 0; bus.BranchEn = 0;
    bus.BranchTaken = 1; bus.BranchPtr = 5'd0; step(); bus.BranchTaken = 0;
    lit("taken_no_en", 10'h041, 1, 0);

    branch(5'd6, 0); lit("at64", 10'h064, 1, 0);
    bus.HaltReq = 1; branch(5'd0, 0); bus.HaltReq = 0;
    lit("halt_prio", 10'h064, 0, 1);
    tbl_write(5'd8, 10'h123);
    lit("halt_hold", 10'h064, 0, 1);
    bus.Start = 1; step();
    lit("halt_start", 10'h000, 1, 0);
    step(); lit("start_in_run1", 10'h001, 1, 0);
    step(); bus.Start = 0;
    lit("start_in_run2", 10'h002, 1, 0);
    branch(5'd8, 0); lit("halt_write", 10'h123, 1, 0);

    branch(5'd7, 0); lit("at52", 10'h052, 1, 0);
    rst_n = 0; bus.TblWrEn = 1; bus.TblWrAddr = 5'd0; bus.TblWrData = 10'h3AB;
    bus.Start = 1;
    step();
    bus.TblWrEn = 0; bus.Start = 0;
    lit("mid_reset", 10'h000, 0, 0);
    rst_n = 1;
    step(); lit("post_reset_idle", 10'h000, 0, 0);
    bus.Start = 1; step(); bus.Start = 0;
    branch(5'd0, 0); lit("dropped_write", 10'h001, 1, 0);
    branch(5'd5, 0); lit("cleared5", 10'h001, 1, 0);
    branch(5'd1, 1); lit("cleared1_rel", 10'h002, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
